adder_result_accumulator: RTL and testbench

- Downstream stage of the registered 2-bit synchronous adder.
- Consumes the adder's registered Carry/Sum each cycle and accumulates COUNT_N valid 3-bit results into an ACC_W-bit batch total.
- Presents the total to the next consumer over a valid/ready handshake.
- Aligns an upstream operand-valid strobe with the adder's fixed pipeline latency.

---
 rtl/adder_acc_pkg.sv | 17 +
 rtl/adder_result_accumulator_if.sv | 30 +++
 rtl/valid_delay_line.sv | 35 +++
 rtl/adder_result_accumulator.sv | 132 +++++++++++++
 tb/tb_adder_result_accumulator.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_acc_pkg.sv
// Shared definitions for the adder result accumulator slice: FSM state
// encoding and the width of one registered adder result ({Carry,Sum}).
package adder_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // One adder result is {carry, sum[1:0]}, values 0..7
    localparam int RES_W = 3;

    // Batch counter width, large enough for COUNT_N up to 255
    localparam int CNT_W = 8;

endpackage

// File: rtl/adder_result_accumulator_if.sv
// Handshake/bus bundle between the adder stage, the accumulator and the
// downstream consumer. The master side drives operands-valid, the adder
// result, clear and ready; the slave side (the accumulator) returns the
// batch total and its status flags.
interface adder_result_accumulator_if #(
    parameter int ACC_W = 8
);

    logic             in_valid;
    logic             carry;
    logic [1:0]       sum;
    logic             clear;
    logic             acc_ready;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             busy;
    logic             overflow;
    logic             overrun;

    modport master (
        output in_valid, carry, sum, clear, acc_ready,
        input  acc_out, acc_valid, busy, overflow, overrun
    );

    modport slave (
        input  in_valid, carry, sum, clear, acc_ready,
        output acc_out, acc_valid, busy, overflow, overrun
    );

endinterface

// File: rtl/valid_delay_line.sv
// Generic valid-strobe delay line: delays a single-bit strobe by LAT clock
// cycles so it lines up with the output of a LAT-stage registered datapath.
module valid_delay_line #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic out_valid
);

    logic [LAT-1:0] dly_q;
    logic [LAT-1:0] dly_d;

    // Shift the strobe one stage per cycle, newest entry at bit 0
    always_comb begin
        dly_d    = dly_q;
        dly_d[0] = in_valid;
        for (int i = 1; i < LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // Pipeline registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    assign out_valid = dly_q[LAT-1];

endmodule

// File: rtl/adder_result_accumulator.sv
// Accumulates COUNT_N aligned adder results into an ACC_W-bit batch total
// and offers it downstream over a valid/ready handshake.
// Optional build macro: ADDER_ACC_SATURATE_EN -- when defined the
// accumulator saturates at all-ones on carry out instead of wrapping.
module adder_result_accumulator
    import adder_acc_pkg::*;
#(
    parameter int ACC_W   = 8,
    parameter int COUNT_N = 4,
    parameter int LAT     = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    adder_result_accumulator_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT_N - 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               overflow_q, overflow_d;
    logic               overrun_q, overrun_d;
    logic               hold_q, hold_d;

    logic               r_valid;
    logic [RES_W-1:0]   value;
    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   acc_add;

    valid_delay_line #(
        .LAT (LAT)
    ) u_valid_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .out_valid (r_valid)
    );

    assign value = {bus.carry, bus.sum};

    // One-bit-wider add so the carry out is visible for overflow detection
    always_comb begin
        sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - RES_W){1'b0}}, value};
`ifdef ADDER_ACC_SATURATE_EN
        acc_add = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        acc_add = sum_ext[ACC_W-1:0];
`endif
    end

    // Next-state and datapath update; clear overrides every other event
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        overrun_d  = overrun_q;
        if (bus.clear) begin
            state_d    = IDLE;
            acc_d      = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (r_valid) begin
                        acc_d   = {{(ACC_W - RES_W){1'b0}}, value};
                        cnt_d   = CNT_W'(1);
                        state_d = (COUNT_N == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (r_valid) begin
                        acc_d = acc_add;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (sum_ext[ACC_W]) begin
                            overflow_d = 1'b1;
                        end
                        if (cnt_q == LAST_CNT) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (r_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (bus.acc_ready) begin
                        state_d    = IDLE;
                        acc_d      = '0;
                        cnt_d      = '0;
                        overflow_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
        hold_d = (state_d == HOLD);
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            overrun_q  <= overrun_d;
            hold_q     <= hold_d;
        end
    end

    assign bus.acc_out   = acc_q;
    assign bus.acc_valid = hold_q;
    assign bus.busy      = hold_q;
    assign bus.overflow  = overflow_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench for adder_result_accumulator. Three instances cover the
// default build, a narrow ACC_W=4 accumulator and a COUNT_N=1 batch.
module tb_adder_result_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [2:0] vec [8];
    int         vec_n;
    int         clear_at;
    bit         early_valid;
    int         xfers;

`ifdef ADDER_ACC_SATURATE_EN
    localparam logic [3:0] EXP_NARROW = 4'd15;
`else
    localparam logic [3:0] EXP_NARROW = 4'd12;
`endif

    adder_result_accumulator_if #(.ACC_W(8)) bus_a ();
    adder_result_accumulator_if #(.ACC_W(4)) bus_b ();
    adder_result_accumulator_if #(.ACC_W(8)) bus_c ();

    adder_result_accumulator #(.ACC_W(8), .COUNT_N(4), .LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    adder_result_accumulator #(.ACC_W(4), .COUNT_N(4), .LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));
    adder_result_accumulator #(.ACC_W(8), .COUNT_N(1), .LAT(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c));

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input int which, input logic iv, input logic [2:0] v,
                           input logic clr, input logic rdy);
        case (which)
            0: begin
                bus_a.in_valid = iv; {bus_a.carry, bus_a.sum} = v;
                bus_a.clear = clr; bus_a.acc_ready = rdy;
            end
            1: begin
                bus_b.in_valid = iv; {bus_b.carry, bus_b.sum} = v;
                bus_b.clear = clr; bus_b.acc_ready = rdy;
            end
            default: begin
                bus_c.in_valid = iv; {bus_c.carry, bus_c.sum} = v;
                bus_c.clear = clr; bus_c.acc_ready = rdy;
            end
        endcase
    endtask

    function automatic logic get_valid(input int which);
        case (which)
            0:       return bus_a.acc_valid;
            1:       return bus_b.acc_valid;
            default: return bus_c.acc_valid;
        endcase
    endfunction

    // Issue vec_n operands, present each result two cycles later as the
    // adder would, optionally pulsing clear in cycle clear_at
    task automatic drive(input int which);
        int idx;
        early_valid = 1'b0;
        for (int i = 0; i < vec_n + 2; i++) begin
            idx = (i >= 2) ? i - 2 : 0;
            set_bus(which, (i < vec_n), (i >= 2) ? vec[idx] : 3'd0, (i == clear_at), 1'b0);
            step();
            if (i < vec_n + 1 && get_valid(which)) early_valid = 1'b1;
        end
        set_bus(which, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic load4(input logic [2:0] v0, input logic [2:0] v1,
                         input logic [2:0] v2, input logic [2:0] v3);
        vec[0] = v0; vec[1] = v1; vec[2] = v2; vec[3] = v3;
        vec_n = 4;
        clear_at = -1;
    endtask

    task automatic test_reset();
        set_bus(0, 1'b0, 3'd0, 1'b0, 1'b0);
        set_bus(1, 1'b0, 3'd0, 1'b0, 1'b0);
        set_bus(2, 1'b0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus_a.acc_out, bus_a.acc_valid, bus_a.busy, bus_a.overflow, bus_a.overrun} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_a: got out=%0d flags=%b expected all 0", bus_a.acc_out,
                     {bus_a.acc_valid, bus_a.busy, bus_a.overflow, bus_a.overrun});
        end
        checks++;
        if ({bus_b.acc_out, bus_c.acc_out, bus_b.acc_valid, bus_c.acc_valid} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL reset_bc: got b=%0d c=%0d expected 0", bus_b.acc_out, bus_c.acc_out);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        load4(3'd3, 3'd5, 3'd7, 3'd1);
        drive(0);
        checks++;
        if (early_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_early_valid: got %b expected 0", early_valid);
        end
        checks++;
        if ({bus_a.acc_valid, bus_a.busy, bus_a.acc_out, bus_a.overflow} !== {1'b1, 1'b1, 8'd16, 1'b0}) begin
            errors++;
            $display("[TB] FAIL basic_total: got valid=%b busy=%b out=%0d ovf=%b expected 1 1 16 0",
                     bus_a.acc_valid, bus_a.busy, bus_a.acc_out, bus_a.overflow);
        end
        set_bus(0, 1'b0, 3'd0, 1'b0, 1'b1);
        step();
        set_bus(0, 1'b0, 3'd0, 1'b0, 1'b0);
        checks++;
        if ({bus_a.acc_valid, bus_a.busy, bus_a.acc_out} !== {1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL basic_after_xfer: got valid=%b busy=%b out=%0d expected 0 0 0",
                     bus_a.acc_valid, bus_a.busy, bus_a.acc_out);
        end
    endtask

    task automatic test_hold_overrun();
        load4(3'd3, 3'd5, 3'd7, 3'd1);
        drive(0);
        set_bus(0, 1'b1, 3'd0, 1'b0, 1'b0);
        step();
        set_bus(0, 1'b0, 3'd0, 1'b0, 1'b0);
        step();
        set_bus(0, 1'b0, 3'd6, 1'b0, 1'b0);
        step();
        set_bus(0, 1'b0, 3'd0, 1'b0, 1'b0);
        checks++;
        if ({bus_a.acc_valid, bus_a.busy, bus_a.acc_out, bus_a.overrun} !== {1'b1, 1'b1, 8'd16, 1'b1}) begin
            errors++;
            $display("[TB] FAIL hold_stable: got valid=%b busy=%b out=%0d ovr=%b expected 1 1 16 1",
                     bus_a.acc_valid, bus_a.busy, bus_a.acc_out, bus_a.overrun);
        end
        set_bus(0, 1'b0, 3'd0, 1'b0, 1'b1);
        step();
        set_bus(0, 1'b0, 3'd0, 1'b0, 1'b0);
        checks++;
        if ({bus_a.acc_valid, bus_a.acc_out, bus_a.overrun} !== {1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL hold_xfer: got valid=%b out=%0d ovr=%b expected 0 0 1",
                     bus_a.acc_valid, bus_a.acc_out, bus_a.overrun);
        end
    endtask

    task automatic test_clear();
        vec[0] = 3'd2; vec[1] = 3'd4; vec[2] = 3'd5;
        vec_n = 3;
        clear_at = 4;
        drive(0);
        checks++;
        if ({bus_a.acc_valid, bus_a.acc_out, bus_a.overflow, bus_a.overrun} !== {1'b0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL clear_state: got valid=%b out=%0d ovf=%b ovr=%b expected 0 0 0 0",
                     bus_a.acc_valid, bus_a.acc_out, bus_a.overflow, bus_a.overrun);
        end
        load4(3'd1, 3'd1, 3'd1, 3'd1);
        drive(0);
        checks++;
        if ({bus_a.acc_valid, bus_a.acc_out} !== {1'b1, 8'd4}) begin
            errors++;
            $display("[TB] FAIL clear_next_batch: got valid=%b out=%0d expected 1 4",
                     bus_a.acc_valid, bus_a.acc_out);
        end
        set_bus(0, 1'b0, 3'd0, 1'b0, 1'b1);
        step();
        set_bus(0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        vec[0] = 3'd4; vec[1] = 3'd5;
        vec_n = 2;
        clear_at = -1;
        drive(0);
        checks++;
        if ({bus_a.acc_valid, bus_a.acc_out} !== {1'b0, 8'd9}) begin
            errors++;
            $display("[TB] FAIL mid_accum: got valid=%b out=%0d expected 0 9", bus_a.acc_valid, bus_a.acc_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.acc_out, bus_a.acc_valid, bus_a.overflow, bus_a.overrun} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got out=%0d expected 0", bus_a.acc_out);
        end
        #2;
        rst_n = 1'b1;
        load4(3'd7, 3'd7, 3'd7, 3'd7);
        drive(0);
        checks++;
        if ({bus_a.acc_valid, bus_a.acc_out, bus_a.overflow} !== {1'b1, 8'd28, 1'b0}) begin
            errors++;
            $display("[TB] FAIL post_reset_batch: got valid=%b out=%0d ovf=%b expected 1 28 0",
                     bus_a.acc_valid, bus_a.acc_out, bus_a.overflow);
        end
        set_bus(0, 1'b0, 3'd0, 1'b0, 1'b1);
        step();
        set_bus(0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        load4(3'd7, 3'd7, 3'd7, 3'd7);
        drive(1);
        checks++;
        if ({bus_b.acc_valid, bus_b.acc_out, bus_b.overflow} !== {1'b1, EXP_NARROW, 1'b1}) begin
            errors++;
            $display("[TB] FAIL narrow_overflow: got valid=%b out=%0d ovf=%b expected 1 %0d 1",
                     bus_b.acc_valid, bus_b.acc_out, bus_b.overflow, EXP_NARROW);
        end
        set_bus(1, 1'b0, 3'd0, 1'b0, 1'b1);
        step();
        set_bus(1, 1'b0, 3'd0, 1'b0, 1'b0);
        checks++;
        if ({bus_b.acc_valid, bus_b.acc_out, bus_b.overflow} !== {1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL narrow_ovf_clear: got valid=%b out=%0d ovf=%b expected 0 0 0",
                     bus_b.acc_valid, bus_b.acc_out, bus_b.overflow);
        end
    endtask

    task automatic test_back_to_back();
        vec[0] = 3'd6;
        vec_n = 1;
        clear_at = -1;
        drive(2);
        checks++;
        if ({early_valid, bus_c.acc_valid, bus_c.acc_out} !== {1'b0, 1'b1, 8'd6}) begin
            errors++;
            $display("[TB] FAIL single_batch: got early=%b valid=%b out=%0d expected 0 1 6",
                     early_valid, bus_c.acc_valid, bus_c.acc_out);
        end
        xfers = 0;
        set_bus(2, 1'b0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (bus_c.acc_valid && bus_c.acc_ready) xfers++;
            step();
        end
        set_bus(2, 1'b0, 3'd0, 1'b0, 1'b0);
        checks++;
        if (xfers !== 1) begin
            errors++;
            $display("[TB] FAIL single_xfer_count: got %0d expected 1", xfers);
        end
        checks++;
        if ({bus_c.acc_valid, bus_c.acc_out} !== {1'b0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL single_idle: got valid=%b out=%0d expected 0 0",
                     bus_c.acc_valid, bus_c.acc_out);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_basic();
        test_hold_overrun();
        test_clear();
        test_async_reset();
        test_overflow();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
